multi_core_scheduler: RTL and testbench

//  Parametrised successor to the two-core Scheduler. It dispatches process ids (pids) onto NUM_CORES cores, using a FIFO ready queue.
//  The processor control unit issues schedule/deschedule commands through an enabled/finished handshake.
//  Per core it drives active, pid and needs-resume-awake signals to the core wrappers, and it reports canHalt to the top level.

---
 rtl/multi_core_scheduler_if.sv | 38 +++
 rtl/multi_core_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_multi_core_scheduler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multi_core_scheduler_if.sv
// Command and core-status bundle between the processor control unit and the scheduler.
interface multi_core_scheduler_if #(
    parameter int unsigned addrBits    = 16,
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned QUEUE_DEPTH = 8
);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

    logic                            enabled;
    logic                            finished;
    logic [NUM_CORES-1:0]            coreReadyForDeschedule;
    logic                            hasDeschedule;
    logic [addrBits-1:0]             deschedulePid;
    logic                            hasSchedule;
    logic [addrBits-1:0]             schedulePid;
    logic [NUM_CORES-1:0]            coreActive;
    logic [NUM_CORES*addrBits-1:0]   corePid;
    logic [NUM_CORES-1:0]            coreNeedsResumeAwake;
    logic [CntW-1:0]                 queueCount;
    logic                            queueOverflow;
    logic                            canHalt;

    // Control unit / core-wrapper side
    modport master (
        output enabled, coreReadyForDeschedule, hasDeschedule, deschedulePid,
               hasSchedule, schedulePid,
        input  finished, coreActive, corePid, coreNeedsResumeAwake, queueCount,
               queueOverflow, canHalt
    );

    // Scheduler side
    modport slave (
        input  enabled, coreReadyForDeschedule, hasDeschedule, deschedulePid,
               hasSchedule, schedulePid,
        output finished, coreActive, corePid, coreNeedsResumeAwake, queueCount,
               queueOverflow, canHalt
    );
endinterface

// File: rtl/multi_core_scheduler.sv
// Dispatches pids onto NUM_CORES cores through a circular FIFO ready queue.
// A command runs IDLE -> DESCHED -> ENQ -> DISPATCH -> DONE -> WAIT -> IDLE.
module multi_core_scheduler #(
    parameter int unsigned addrBits    = 16,
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    multi_core_scheduler_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned CoreW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDesched,
        StEnq,
        StDispatch,
        StDone,
        StWait
    } state_e;

    state_e                                  state_q, state_d;
    logic                                    has_desched_q, has_desched_d;
    logic [addrBits-1:0]                     desched_pid_q, desched_pid_d;
    logic                                    has_sched_q, has_sched_d;
    logic [addrBits-1:0]                     sched_pid_q, sched_pid_d;
    logic [NUM_CORES-1:0]                    core_active_q, core_active_d;
    logic [NUM_CORES-1:0][addrBits-1:0]      core_pid_q, core_pid_d;
    logic [NUM_CORES-1:0]                    core_resume_q, core_resume_d;
    logic [QUEUE_DEPTH-1:0][addrBits-1:0]    queue_q, queue_d;
    logic [PtrW-1:0]                         head_q, head_d;
    logic [PtrW-1:0]                         tail_q, tail_d;
    logic [CntW-1:0]                         count_q, count_d;
    logic                                    overflow_q, overflow_d;

    logic             match_found;
    logic [CoreW-1:0] match_idx;
    logic             free_found;
    logic [CoreW-1:0] free_idx;

    // Lowest active core holding the deschedule pid, and lowest inactive core
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!match_found && core_active_q[i] && core_pid_q[i] == desched_pid_q) begin
                match_found = 1'b1;
                match_idx   = CoreW'(i);
            end
            if (!free_found && !core_active_q[i]) begin
                free_found = 1'b1;
                free_idx   = CoreW'(i);
            end
        end
    end

    // Next-state logic for the command FSM, core table and ready queue
    always_comb begin
        state_d       = state_q;
        has_desched_d = has_desched_q;
        desched_pid_d = desched_pid_q;
        has_sched_d   = has_sched_q;
        sched_pid_d   = sched_pid_q;
        core_active_d = core_active_q;
        core_pid_d    = core_pid_q;
        core_resume_d = core_resume_q;
        queue_d       = queue_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (bus.enabled) begin
                    has_desched_d = bus.hasDeschedule;
                    desched_pid_d = bus.deschedulePid;
                    has_sched_d   = bus.hasSchedule;
                    sched_pid_d   = bus.schedulePid;
                    core_resume_d = '0;
                    state_d       = StDesched;
                end
            end
            StDesched: begin
                if (has_desched_q && match_found) begin
                    // Hold here until the core signals it can be taken away
                    if (bus.coreReadyForDeschedule[match_idx]) begin
                        core_active_d[match_idx] = 1'b0;
                        state_d                  = StEnq;
                    end
                end else begin
                    state_d = StEnq;
                end
            end
            StEnq: begin
                if (has_sched_q) begin
                    if (count_q == CntW'(QUEUE_DEPTH)) begin
                        overflow_d = 1'b1;
                    end else begin
                        queue_d[tail_q] = sched_pid_q;
                        tail_d          = tail_q + PtrW'(1);
                        count_d         = count_q + CntW'(1);
                    end
                end
                state_d = StDispatch;
            end
            StDispatch: begin
                if (count_q != '0 && free_found) begin
                    core_active_d[free_idx] = 1'b1;
                    core_pid_d[free_idx]    = queue_q[head_q];
                    core_resume_d[free_idx] = 1'b1;
                    head_d                  = head_q + PtrW'(1);
                    count_d                 = count_q - CntW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StWait;
            end
            StWait: begin
                if (!bus.enabled) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            has_desched_q <= 1'b0;
            desched_pid_q <= '0;
            has_sched_q   <= 1'b0;
            sched_pid_q   <= '0;
            core_active_q <= '0;
            core_pid_q    <= '0;
            core_resume_q <= '0;
            queue_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            has_desched_q <= has_desched_d;
            desched_pid_q <= desched_pid_d;
            has_sched_q   <= has_sched_d;
            sched_pid_q   <= sched_pid_d;
            core_active_q <= core_active_d;
            core_pid_q    <= core_pid_d;
            core_resume_q <= core_resume_d;
            queue_q       <= queue_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    // Output drive; finished is decoded from the registered state so it is glitch-free
    always_comb begin
        bus.finished             = (state_q == StDone);
        bus.coreActive           = core_active_q;
        bus.corePid              = core_pid_q;
        bus.coreNeedsResumeAwake = core_resume_q;
        bus.queueCount           = count_q;
        bus.queueOverflow        = overflow_q;
        bus.canHalt              = (core_active_q == '0) && (count_q == '0);
    end
endmodule

// File: tb/tb_multi_core_scheduler.sv
// Directed bench: a 2-core instance for basic dispatch and a 4-core, 4-deep instance
// for overflow, queue wrap, deschedule stall and mid-command reset.
module tb_multi_core_scheduler;
    logic clk;
    logic rst2_n;
    logic rst4_n;
    int   n_vec;
    int   n_bad;
    int   lat;

    multi_core_scheduler_if #(.addrBits(16), .NUM_CORES(2), .QUEUE_DEPTH(8)) b2 ();
    multi_core_scheduler_if #(.addrBits(16), .NUM_CORES(4), .QUEUE_DEPTH(4)) b4 ();

    multi_core_scheduler #(.addrBits(16), .NUM_CORES(2), .QUEUE_DEPTH(8)) u_dut2 (
        .clk   (clk),
        .reset (rst2_n),
        .bus   (b2)
    );

    multi_core_scheduler #(.addrBits(16), .NUM_CORES(4), .QUEUE_DEPTH(4)) u_dut4 (
        .clk   (clk),
        .reset (rst4_n),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command on the selected instance; ready is held low for `hold` DESCHED cycles.
    task automatic run_cmd(input bit sel, input bit hd, input logic [15:0] dp, input bit hs,
                           input logic [15:0] sp, input int hold, output int lat_o);
        bit fin;
        @(negedge clk);
        if (sel) begin
            b4.hasDeschedule = hd; b4.deschedulePid = dp;
            b4.hasSchedule = hs;   b4.schedulePid = sp;
            if (hold > 0) b4.coreReadyForDeschedule = '0;
            b4.enabled = 1'b1;
        end else begin
            b2.hasDeschedule = hd; b2.deschedulePid = dp;
            b2.hasSchedule = hs;   b2.schedulePid = sp;
            if (hold > 0) b2.coreReadyForDeschedule = '0;
            b2.enabled = 1'b1;
        end
        lat_o = 0;
        fin   = 1'b0;
        while (!fin && lat_o < 60) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (lat_o == hold + 1) begin
                b4.coreReadyForDeschedule = '1;
                b2.coreReadyForDeschedule = '1;
            end
            fin = sel ? b4.finished : b2.finished;
        end
        if (!fin) check_val("finished_timeout", 64'(fin), 64'd1);
        @(negedge clk);
        b2.enabled = 1'b0;
        b4.enabled = 1'b0;
        @(posedge clk);
        #1;
        check_val("finished_one_cycle", 64'(sel ? b4.finished : b2.finished), 64'd0);
        @(posedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst2_n = 1'b0;
        rst4_n = 1'b0;
        b2.enabled = 1'b0; b2.coreReadyForDeschedule = '1;
        b2.hasDeschedule = 1'b0; b2.deschedulePid = '0;
        b2.hasSchedule = 1'b0;   b2.schedulePid = '0;
        b4.enabled = 1'b0; b4.coreReadyForDeschedule = '1;
        b4.hasDeschedule = 1'b0; b4.deschedulePid = '0;
        b4.hasSchedule = 1'b0;   b4.schedulePid = '0;
        #12;
        check_val("rst_active", 64'(b2.coreActive), 64'd0);
        check_val("rst_pid", 64'(b2.corePid), 64'd0);
        check_val("rst_count", 64'(b2.queueCount), 64'd0);
        check_val("rst_canhalt", 64'(b2.canHalt), 64'd1);
        check_val("rst_finished", 64'(b2.finished), 64'd0);
        @(negedge clk);
        rst2_n = 1'b1;
        rst4_n = 1'b1;

        // 2-core: schedule 1, 2, 3
        run_cmd(0, 0, 0, 1, 16'd1, 0, lat);
        check_val("t1_lat1", 64'(lat), 64'd5);
        check_val("t1_core0", 64'(b2.corePid[15:0]), 64'd1);
        check_val("t1_res1", 64'(b2.coreNeedsResumeAwake), 64'b01);
        run_cmd(0, 0, 0, 1, 16'd2, 0, lat);
        check_val("t1_core1", 64'(b2.corePid[31:16]), 64'd2);
        check_val("t1_res2", 64'(b2.coreNeedsResumeAwake), 64'b10);
        check_val("t1_act2", 64'(b2.coreActive), 64'b11);
        run_cmd(0, 0, 0, 1, 16'd3, 0, lat);
        check_val("t1_lat3", 64'(lat), 64'd4);
        check_val("t1_count3", 64'(b2.queueCount), 64'd1);
        check_val("t1_res3", 64'(b2.coreNeedsResumeAwake), 64'b00);

        // Deschedule 1: queued 3 takes core 0
        run_cmd(0, 1, 16'd1, 0, 0, 0, lat);
        check_val("t2_lat", 64'(lat), 64'd5);
        check_val("t2_core0", 64'(b2.corePid[15:0]), 64'd3);
        check_val("t2_core1", 64'(b2.corePid[31:16]), 64'd2);
        check_val("t2_res", 64'(b2.coreNeedsResumeAwake), 64'b01);
        check_val("t2_count", 64'(b2.queueCount), 64'd0);
        check_val("t2_canhalt", 64'(b2.canHalt), 64'd0);

        // Deschedule 2 + schedule 4 in one command
        run_cmd(0, 1, 16'd2, 1, 16'd4, 0, lat);
        check_val("t3_lat", 64'(lat), 64'd5);
        check_val("t3_core1", 64'(b2.corePid[31:16]), 64'd4);
        check_val("t3_core0", 64'(b2.corePid[15:0]), 64'd3);
        check_val("t3_res", 64'(b2.coreNeedsResumeAwake), 64'b10);
        run_cmd(0, 1, 16'd3, 0, 0, 0, lat);
        run_cmd(0, 1, 16'd4, 0, 0, 0, lat);
        check_val("t3_act", 64'(b2.coreActive), 64'b00);
        check_val("t3_canhalt", 64'(b2.canHalt), 64'd1);

        // 4-core, 4-deep: schedule 1..9
        for (int p = 1; p <= 9; p++) begin
            run_cmd(1, 0, 0, 1, 16'(p), 0, lat);
        end
        check_val("t4_pids", 64'(b4.corePid), 64'h0004_0003_0002_0001);
        check_val("t4_count", 64'(b4.queueCount), 64'd4);
        check_val("t4_ovf", 64'(b4.queueOverflow), 64'd1);
        check_val("t4_lat9", 64'(lat), 64'd4);

        // Deschedule 2 with a 3-cycle stall; 5 takes core 1
        run_cmd(1, 1, 16'd2, 0, 0, 3, lat);
        check_val("t5_lat", 64'(lat), 64'd8);
        check_val("t5_core1", 64'(b4.corePid[31:16]), 64'd5);
        check_val("t5_count", 64'(b4.queueCount), 64'd3);
        check_val("t5_res", 64'(b4.coreNeedsResumeAwake), 64'b0010);
        // Push 10 into the wrapped tail slot, then drain in FIFO order
        run_cmd(1, 0, 0, 1, 16'd10, 0, lat);
        check_val("t5_count4", 64'(b4.queueCount), 64'd4);
        run_cmd(1, 1, 16'd1, 0, 0, 0, lat);
        run_cmd(1, 1, 16'd3, 0, 0, 0, lat);
        run_cmd(1, 1, 16'd4, 0, 0, 0, lat);
        run_cmd(1, 1, 16'd5, 0, 0, 0, lat);
        check_val("t5_wrap_pids", 64'(b4.corePid), 64'h0008_0007_000A_0006);
        check_val("t5_count0", 64'(b4.queueCount), 64'd0);
        // Unknown pid
        run_cmd(1, 1, 16'd77, 0, 0, 0, lat);
        check_val("t5_unk_lat", 64'(lat), 64'd4);
        check_val("t5_unk_pids", 64'(b4.corePid), 64'h0008_0007_000A_0006);
        check_val("t5_unk_act", 64'(b4.coreActive), 64'b1111);

        // Queue 11, then reset while a deschedule of 6 is dispatching
        run_cmd(1, 0, 0, 1, 16'd11, 0, lat);
        check_val("t6_count", 64'(b4.queueCount), 64'd1);
        @(negedge clk);
        b4.hasDeschedule = 1'b1; b4.deschedulePid = 16'd6;
        b4.hasSchedule = 1'b0;
        b4.enabled = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst4_n = 1'b0;
        #1;
        check_val("t6_act", 64'(b4.coreActive), 64'd0);
        check_val("t6_pid", 64'(b4.corePid), 64'd0);
        check_val("t6_res", 64'(b4.coreNeedsResumeAwake), 64'd0);
        check_val("t6_cnt", 64'(b4.queueCount), 64'd0);
        check_val("t6_ovf", 64'(b4.queueOverflow), 64'd0);
        check_val("t6_canhalt", 64'(b4.canHalt), 64'd1);
        check_val("t6_fin", 64'(b4.finished), 64'd0);
        b4.enabled = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_val("t6_no_fin", 64'(b4.finished), 64'd0);
        end
        @(negedge clk);
        rst4_n = 1'b1;
        run_cmd(1, 0, 0, 1, 16'd1, 0, lat);
        check_val("t6_post_lat", 64'(lat), 64'd5);
        check_val("t6_post_core0", 64'(b4.corePid[15:0]), 64'd1);
        check_val("t6_post_act", 64'(b4.coreActive), 64'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
